// File: rtl/sb_trans_ctrl.sv
// Scoreboard sequencing: in-order trans_id allocation, out-of-order writeback completion,
// and in-order release to commit over an NR_ENTRIES-deep ring.

module sb_trans_entry (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic alloc,
   input  logic wb_set,
   input  logic retire,
   output logic valid,
   output logic done
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (alloc) begin
         valid <= 1'b1;
         done  <= 1'b0;
      end else if (retire) begin
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (wb_set) begin
         done  <= 1'b1;
      end
   end
endmodule

module sb_trans_ctrl #(
   parameter int NR_ENTRIES    = 4,
   parameter int NR_WB_PORTS   = 3,
   parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   input  logic                                   issue_valid_i,
   output logic                                   issue_ready_o,
   output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
   input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
   output logic                                   commit_valid_o,
   output logic [TRANS_ID_BITS-1:0]               commit_trans_id_o,
   input  logic                                   commit_ack_i,
   output logic [TRANS_ID_BITS:0]                 count_o,
   output logic                                   full_o,
   output logic                                   empty_o,
   output logic                                   wb_err_o
);
   localparam logic [TRANS_ID_BITS:0]   FULL_CNT = (TRANS_ID_BITS+1)'(NR_ENTRIES);
   localparam logic [TRANS_ID_BITS:0]   CNT_ONE  = (TRANS_ID_BITS+1)'(1);
   localparam logic [TRANS_ID_BITS-1:0] PTR_ONE  = TRANS_ID_BITS'(1);

   logic [TRANS_ID_BITS-1:0] issue_ptr, commit_ptr;
   logic [TRANS_ID_BITS:0]   count;
   logic [NR_ENTRIES-1:0]    ent_valid, ent_done, wb_hit;
   logic [TRANS_ID_BITS-1:0] wb_id [NR_WB_PORTS];
   logic                     wb_bad, wb_err;
   logic                     issue_fire, commit_fire;

   assign full_o            = (count == FULL_CNT);
   assign empty_o           = (count == '0);
   assign count_o           = count;
   assign issue_ready_o     = !full_o && !flush_i;
   assign issue_trans_id_o  = issue_ptr;
   assign commit_valid_o    = ent_valid[commit_ptr] && ent_done[commit_ptr] && !flush_i;
   assign commit_trans_id_o = commit_ptr;
   assign wb_err_o          = wb_err;
   assign issue_fire        = issue_valid_i && issue_ready_o;
   assign commit_fire       = commit_ack_i && commit_valid_o;

   for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_id
      assign wb_id[p] = wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
   end

   // Qualify against state at cycle start; an entry allocated this cycle is still invalid here,
   // and several ports hitting the same live id simply set it once.
   always_comb begin
      wb_hit = '0;
      wb_bad = 1'b0;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
         if (wb_valid_i[p]) begin
            if (ent_valid[wb_id[p]] && !ent_done[wb_id[p]]) wb_hit[wb_id[p]] = 1'b1;
            else                                          wb_bad = 1'b1;
         end
      end
   end

   for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_ent
      sb_trans_entry u_ent (
         .clk    (clk_i),
         .rst    (rst_i),
         .flush  (flush_i),
         .alloc  (issue_fire && (issue_ptr == TRANS_ID_BITS'(e))),
         .wb_set (wb_hit[e]),
         .retire (commit_fire && (commit_ptr == TRANS_ID_BITS'(e))),
         .valid  (ent_valid[e]),
         .done   (ent_done[e])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         issue_ptr  <= '0;
         commit_ptr <= '0;
         count      <= '0;
         wb_err     <= 1'b0;
      end else if (flush_i) begin
         issue_ptr  <= '0;
         commit_ptr <= '0;
         count      <= '0;
         wb_err     <= 1'b0;
      end else begin
         wb_err <= wb_bad;
         if (issue_fire)  issue_ptr  <= issue_ptr + PTR_ONE;
         if (commit_fire) commit_ptr <= commit_ptr + PTR_ONE;
         case ({issue_fire, commit_fire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count <= FULL_CNT);
   a_no_issue_full: assert property (@(posedge clk_i) disable iff (rst_i) !(issue_fire && full_o));
endmodule

// File: tb/tb_sb_trans_ctrl.sv
// Directed bench for sb_trans_ctrl: issued ids go into a scoreboard queue, a negedge monitor
// checks every commit handshake against it; other outputs are checked against hand values.

module tb_sb_trans_ctrl;
   localparam int TB = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          issue_valid = 1'b0;
   logic          issue_ready;
   logic [TB-1:0] issue_trans_id;
   logic [2:0]    wb_valid = '0;
   logic [3*TB-1:0] wb_trans_id = '0;
   logic          commit_valid;
   logic [TB-1:0] commit_trans_id;
   logic          commit_ack = 1'b0;
   logic [TB:0]   count;
   logic          full, empty, wb_err;

   int n_checks = 0;
   int n_pass   = 0;
   int sb_q[$];

   sb_trans_ctrl #(.NR_ENTRIES(4), .NR_WB_PORTS(3), .TRANS_ID_BITS(TB)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_trans_id_o(issue_trans_id),
      .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id),
      .commit_valid_o(commit_valid), .commit_trans_id_o(commit_trans_id), .commit_ack_i(commit_ack),
      .count_o(count), .full_o(full), .empty_o(empty), .wb_err_o(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      commit_ack  = 1'b0;
      wb_valid    = '0;
      flush       = 1'b0;
   endtask

   task automatic set_wb(input int p, input int id);
      wb_valid[p] = 1'b1;
      wb_trans_id[p*TB +: TB] = TB'(id);
   endtask

   // Drive an issue and check the id offered; the id joins the expected commit order.
   task automatic do_issue(input int exp_id);
      issue_valid = 1'b1;
      #1;
      chk("issue_ready", int'(issue_ready), 1);
      chk("issue_id", int'(issue_trans_id), exp_id);
      sb_q.push_back(exp_id);
   endtask

   // Commit monitor
   always @(negedge clk) begin
      if (!rst && commit_valid && commit_ack) begin
         if (sb_q.size() == 0) chk("commit_unexpected", int'(commit_trans_id), -1);
         else chk("commit_order", int'(commit_trans_id), sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wrap_seq[6];
      wrap_seq = '{0, 1, 2, 3, 0, 1};

      // Reset state
      #2;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_ready", int'(issue_ready), 1);
      chk("rst_commit_valid", int'(commit_valid), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rel_count", int'(count), 0);
      chk("rel_empty", int'(empty), 1);
      chk("rel_full", int'(full), 0);
      chk("rel_ready", int'(issue_ready), 1);
      chk("rel_issue_id", int'(issue_trans_id), 0);
      chk("rel_commit_valid", int'(commit_valid), 0);
      chk("rel_wb_err", int'(wb_err), 0);

      // Fill: ids 0..3, then a refused fifth request
      for (int i = 0; i < 4; i++) begin
         do_issue(i);
         tick();
         chk("fill_count", int'(count), i + 1);
      end
      chk("fill_full", int'(full), 1);
      chk("fill_empty", int'(empty), 0);
      issue_valid = 1'b1;
      #1;
      chk("full_ready", int'(issue_ready), 0);
      tick();
      chk("full_count_hold", int'(count), 4);

      // Out-of-order writeback: id2 on port1, id0 on port0
      set_wb(1, 2);
      set_wb(0, 0);
      #1;
      chk("wb_no_bypass", int'(commit_valid), 0);
      tick();
      chk("ooo_commit_valid", int'(commit_valid), 1);
      chk("ooo_commit_id", int'(commit_trans_id), 0);
      chk("ooo_wb_err", int'(wb_err), 0);
      commit_ack = 1'b1;
      tick();
      chk("ooo_blocked_on_1", int'(commit_valid), 0);
      chk("ooo_count3", int'(count), 3);
      commit_ack = 1'b1;
      tick();
      chk("ack_ignored_count", int'(count), 3);
      set_wb(2, 1);
      tick();
      chk("id1_ready", int'(commit_valid), 1);
      commit_ack = 1'b1;
      tick();
      chk("id2_ready", int'(commit_valid), 1);
      chk("id2_id", int'(commit_trans_id), 2);
      commit_ack = 1'b1;
      tick();
      chk("id3_pending", int'(commit_valid), 0);
      chk("id3_count", int'(count), 1);

      // Retire id3, then wrap through six full issue/wb/commit rounds
      set_wb(0, 3);
      tick();
      commit_ack = 1'b1;
      tick();
      chk("drain_empty", int'(empty), 1);
      for (int i = 0; i < 6; i++) begin
         do_issue(wrap_seq[i]);
         tick();
         chk("wrap_count", int'(count), 1);
         set_wb(i % 3, wrap_seq[i]);
         tick();
         commit_ack = 1'b1;
         tick();
         chk("wrap_count0", int'(count), 0);
      end

      // Simultaneous issue + commit + triple writeback to one id
      do_issue(2); tick();
      do_issue(3); tick();
      do_issue(0); tick();
      chk("sim_count3", int'(count), 3);
      set_wb(0, 2);
      tick();
      do_issue(1);
      commit_ack = 1'b1;
      set_wb(0, 3);
      set_wb(1, 3);
      set_wb(2, 3);
      tick();
      chk("sim_count_hold", int'(count), 3);
      chk("sim_wb_err", int'(wb_err), 0);
      chk("sim_id3_done", int'(commit_valid), 1);
      chk("sim_id3_id", int'(commit_trans_id), 3);
      set_wb(1, 2);
      tick();
      chk("free_wb_err", int'(wb_err), 1);
      tick();
      chk("free_wb_err_pulse", int'(wb_err), 0);
      set_wb(0, 3);
      tick();
      chk("done_wb_err", int'(wb_err), 1);
      chk("done_wb_count", int'(count), 3);

      // Flush with issue, ack and writeback in the same cycle
      flush = 1'b1;
      issue_valid = 1'b1;
      commit_ack = 1'b1;
      set_wb(0, 0);
      #1;
      chk("flush_ready", int'(issue_ready), 0);
      chk("flush_commit_valid", int'(commit_valid), 0);
      sb_q.delete();
      tick();
      chk("flush_count", int'(count), 0);
      chk("flush_empty", int'(empty), 1);
      chk("flush_wb_err", int'(wb_err), 0);
      chk("flush_issue_id", int'(issue_trans_id), 0);
      chk("flush_commit_valid_after", int'(commit_valid), 0);
      do_issue(0);
      tick();
      chk("post_flush_count", int'(count), 1);
      set_wb(0, 0);
      tick();
      chk("post_flush_commit", int'(commit_valid), 1);

      // Asynchronous reset mid-stream
      issue_valid = 1'b1;
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_full", int'(full), 0);
      chk("arst_commit_valid", int'(commit_valid), 0);
      chk("arst_issue_id", int'(issue_trans_id), 0);
      chk("arst_ready", int'(issue_ready), 1);
      tick();
      chk("arst_hold_count", int'(count), 0);
      rst = 1'b0;
      #1;
      chk("arst_release_count", int'(count), 0);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
